if_id_stage_buf: RTL and testbench

//  Parametrised IF/ID pipeline stage: a DEPTH-entry in-order buffer carrying {pc, instr} between fetch and decode.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 22 ++
 rtl/if_id_stage_buf.sv | 107 ++++++++++
 tb/tb_if_id_stage_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, constants and helpers for the IF/ID stage
package pipe_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] NOP = 32'h0;

    typedef struct packed {
        logic [XLEN_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } if_id_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage_buf.sv
// rtl/if_id_stage_buf.sv - in-order IF/ID buffer with handshakes, stall, flush and perf counters
module if_id_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 XLEN      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP),
    parameter int                 CNT_W     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [INSTR_W-1:0]      instr_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         pc_o,
    output logic [INSTR_W-1:0]      instr_o,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Same layout as if_id_entry_t, sized by this instance's widths.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic [XLEN-1:0]    last_pc;
    logic               full;
    logic               push;
    logic               pop;

    assign full        = (count == OCC_W'(DEPTH));
    assign out_valid_o = (count != '0);
    // Ready depends only on registered state and flush, never on out_ready_i.
    assign in_ready_o  = !full && !flush_i;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i && !stall_i;
    assign count_o     = count;

    assign pc_o    = out_valid_o ? mem[rd_ptr].pc    : last_pc;
    assign instr_o = out_valid_o ? mem[rd_ptr].instr : NOP_INSTR;

    // Storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= pc_i;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                last_pc <= mem[rd_ptr].pc;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_i && out_valid_o),
        .clr_i   (1'b0),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (flush_i),
        .clr_i   (1'b0),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_if_id_stage_buf.sv
// tb/tb_if_id_stage_buf.sv - randomized and directed bench against a queue-based reference model
module tb_if_id_stage_buf;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP_V = 32'h0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic               stall;
    logic               flush;
    logic [1:0]         count;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    if_id_stage_buf #(
        .XLEN(XLEN), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .NOP_INSTR(NOP_V), .CNT_W(CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .pc_i        (pc_in),
        .instr_i     (instr_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pc_o        (pc_out),
        .instr_o     (instr_out),
        .stall_i     (stall),
        .flush_i     (flush),
        .count_o     (count),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t            q[$];
    logic [XLEN-1:0] m_last_pc;
    int              m_stall;
    int              m_flush;
    int              errors;
    int              checks;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_pc = '0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic check_outs(input string tag);
        logic m_valid;
        m_valid = (q.size() != 0);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".ready"}, 64'(in_ready), 64'((q.size() < DEPTH) && !flush));
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".pc"}, 64'(pc_out), m_valid ? 64'(q[0].pc) : 64'(m_last_pc));
        chk({tag, ".instr"}, 64'(instr_out), m_valid ? 64'(q[0].instr) : 64'(NOP_V));
        chk({tag, ".scnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, ".fcnt"}, 64'(flush_cnt), 64'(m_flush));
    endtask

    // Called at posedge+1 with inputs already driven; checks, advances the model, crosses one edge.
    task automatic cycle(input string tag);
        logic m_valid, do_push, do_pop;
        #1;
        check_outs(tag);
        m_valid = (q.size() != 0);
        do_push = in_valid && (q.size() < DEPTH) && !flush;
        do_pop  = m_valid && out_ready && !stall;
        if (stall && m_valid && m_stall < CNT_MAX) m_stall++;
        if (flush && m_flush < CNT_MAX) m_flush++;
        if (flush) begin
            q.delete();
            m_last_pc = pc_in;
        end else begin
            if (do_pop) begin
                m_last_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{pc: pc_in, instr: instr_in});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic stl, input logic fl);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = ins;
        out_ready = rdy;
        stall     = stl;
        flush     = fl;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst0");
        rst_n = 1'b1;

        drive(1, 32'h100, 32'h0050_0093, 0, 0, 0);
        cycle("t2a");
        chk("t2.valid", 64'(out_valid), 64'd1);
        chk("t2.pc", 64'(pc_out), 64'h100);
        chk("t2.count", 64'(count), 64'd1);

        drive(1, 32'h104, 32'h0010_0113, 0, 0, 0);
        cycle("t3a");
        chk("t3.full_ready", 64'(in_ready), 64'd0);
        drive(1, 32'h108, 32'h0020_0193, 1, 0, 0);
        cycle("t3b");
        chk("t3.count", 64'(count), 64'd1);
        chk("t3.head", 64'(pc_out), 64'h104);

        drive(0, 0, 0, 1, 1, 0);
        repeat (3) cycle("t4");
        chk("t4.head", 64'(pc_out), 64'h104);
        chk("t4.scnt", 64'(stall_cnt), 64'd3);

        drive(1, 32'h10c, 32'h0030_0213, 0, 0, 0);
        cycle("t5a");
        chk("t5.pre_count", 64'(count), 64'd2);
        drive(1, 32'h200, 32'h1234_5678, 0, 0, 1);
        cycle("t5b");
        chk("t5.count", 64'(count), 64'd0);
        chk("t5.instr", 64'(instr_out), 64'(NOP_V));
        chk("t5.pc", 64'(pc_out), 64'h200);
        chk("t5.fcnt", 64'(flush_cnt), 64'd1);

        drive(1, 32'h300, 32'h0040_0293, 0, 0, 0);
        cycle("t6a");
        drive(0, 0, 0, 1, 1, 0);
        repeat (20) cycle("t6");
        chk("t6.sat", 64'(stall_cnt), 64'd15);
        repeat (3) cycle("t6b");
        chk("t6.hold", 64'(stall_cnt), 64'd15);

        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            drive_random();
            cycle("rnd");
        end

        drive(1, 32'hdead_beef, 32'h0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("t1a");
        @(posedge clk);
        #1;
        check_outs("t1b");
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            drive_random();
            cycle("post");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
